// File: rtl/ai_cmp_pkg.sv
// Shared types and sizing helpers for the template-comparer lanes.
package ai_cmp_pkg;

  // Sequencer states of one comparer lane.
  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    CMP,
    DONE
  } cmp_state_t;

  // Default widths used when a lane is instantiated without overrides.
  localparam int DEF_FEAT_W  = 16;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_N_FEAT  = 64;
  localparam int DEF_N_TEMPL = 8;

  // Template RAM address width: one word per (template, sample) pair.
  function automatic int tmpl_addr_w(input int n_feat, input int n_templ);
    return $clog2(n_feat * n_templ);
  endfunction

  // Template index width; a single-template bank still needs one bit.
  function automatic int idx_w(input int n_templ);
    return (n_templ > 1) ? $clog2(n_templ) : 1;
  endfunction

endpackage

// File: rtl/ai_abs_diff.sv
// Combinational |a - b| of two signed samples; result is unsigned, W+1 bits.
module ai_abs_diff #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic        [W:0]   y
);

  logic signed [W:0] diff;

  // Difference of sign-extended operands cannot overflow W+1 bits, and its
  // magnitude (at most 2^W - 1) fits the unsigned W+1-bit result.
  always_comb begin
    diff = {a[W-1], a} - {b[W-1], b};
    y    = diff[W] ? (~diff + 1'b1) : diff;
  end

endmodule

// File: rtl/ai_template_comparer.sv
// One comparer lane: SAD of a feature vector against every template of a bank,
// tracking the lowest score and its template index.
module ai_template_comparer
  import ai_cmp_pkg::*;
#(
  parameter int FEAT_W  = DEF_FEAT_W,
  parameter int N_FEAT  = DEF_N_FEAT,
  parameter int N_TEMPL = DEF_N_TEMPL,
  parameter int ACC_W   = DEF_ACC_W,
  localparam int FA_W   = $clog2(N_FEAT),
  localparam int TA_W   = tmpl_addr_w(N_FEAT, N_TEMPL),
  localparam int IDX_W  = idx_w(N_TEMPL)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [FA_W-1:0]          feat_addr,
  input  logic signed [FEAT_W-1:0] feat_data,
  output logic [TA_W-1:0]          tmpl_addr,
  input  logic signed [FEAT_W-1:0] tmpl_data,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         best_idx,
  output logic [ACC_W-1:0]         best_score
);

  cmp_state_t        state, state_next;
  logic [FA_W-1:0]   i_q;
  logic [IDX_W-1:0]  t_q;
  logic [ACC_W-1:0]  acc_q;
  logic              data_vld_q;
  logic [FEAT_W:0]   abs_d;
  logic [ACC_W:0]    acc_sum;
  logic              last_i;
  logic              last_t;

  assign last_i = (i_q == FA_W'(N_FEAT - 1));
  assign last_t = (t_q == IDX_W'(N_TEMPL - 1));

  ai_abs_diff #(
    .W (FEAT_W)
  ) u_abs_diff (
    .a (feat_data),
    .b (tmpl_data),
    .y (abs_d)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned, which would infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_i) state_next = DRAIN;
      DRAIN:   state_next = CMP;
      CMP:     state_next = last_t ? DONE : RUN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sample counter i and template counter t.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      t_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          i_q <= '0;
          t_q <= '0;
        end
        RUN:  if (!last_i) i_q <= i_q + FA_W'(1);
        CMP: begin
          i_q <= '0;
          if (!last_t) t_q <= t_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // RAM data arrives one cycle after the address, so valid trails RUN by one.
  always_ff @(posedge clk) begin
    if (rst) data_vld_q <= 1'b0;
    else     data_vld_q <= (state == RUN);
  end

  // One extra bit catches the carry out of the SAD add for saturation.
  assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(abs_d);

  // Saturating SAD accumulator, cleared at start and after each template.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if ((state == IDLE && start) || state == CMP) begin
      acc_q <= '0;
    end else if (data_vld_q) begin
      acc_q <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end
  end

  // Best-result tracking; strict compare keeps the lower index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_idx   <= '0;
      best_score <= '1;
    end else if (state == CMP && (t_q == '0 || acc_q < best_score)) begin
      best_idx   <= t_q;
      best_score <= acc_q;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign feat_addr = i_q;
  assign tmpl_addr = TA_W'({t_q, i_q});

endmodule

// File: tb/tb_ai_template_comparer.sv
// Scoreboard bench: four comparer lanes (32-bit score) plus one 17-bit lane
// for saturation, each with a 1-cycle-latency RAM model.
module tb_ai_template_comparer;

  localparam int NF    = 4;
  localparam int NT    = 2;
  localparam int LANES = 5;
  localparam int RUN_LEN = NT * (NF + 2) + 1;

  typedef int vec4_t [4];
  typedef struct {
    int     lane;
    int     cyc;
    int     idx;
    longint score;
  } exp_t;

  logic clk;
  logic rst;
  logic [LANES-1:0] start_v;
  logic [LANES-1:0] done_v;
  logic [LANES-1:0] busy_v;
  logic [LANES-1:0] idx_v;
  logic [31:0]      score_v [LANES];
  logic [1:0]       fa_v    [LANES];
  logic [2:0]       ta_v    [LANES];

  logic signed [15:0] feat_mem [LANES][NF];
  logic signed [15:0] tmpl_mem [LANES][NF*NT];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  // Aggregator model: sticky pending per lane, irq once all four have fired.
  logic [3:0] pend;
  logic       irq;
  assign irq = &pend;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend | done_v[3:0];
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int AW = (g == 4) ? 17 : 32;
    logic signed [15:0] fd, td;
    logic [AW-1:0]      sc;
    logic [1:0]         fa;
    logic [2:0]         ta;
    logic               bi, bz, dn;

    ai_template_comparer #(
      .FEAT_W (16), .N_FEAT (NF), .N_TEMPL (NT), .ACC_W (AW)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_v[g]),
      .feat_addr  (fa),
      .feat_data  (fd),
      .tmpl_addr  (ta),
      .tmpl_data  (td),
      .busy       (bz),
      .done       (dn),
      .best_idx   (bi),
      .best_score (sc)
    );

    always @(posedge clk) begin
      fd <= feat_mem[g][fa];
      td <= tmpl_mem[g][ta];
    end

    assign done_v[g]  = dn;
    assign busy_v[g]  = bz;
    assign idx_v[g]   = bi;
    assign score_v[g] = 32'(sc);
    assign fa_v[g]    = fa;
    assign ta_v[g]    = ta;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_lane(input int lane, input vec4_t f, input vec4_t t0, input vec4_t t1);
    for (int k = 0; k < NF; k++) begin
      feat_mem[lane][k]      = 16'(f[k]);
      tmpl_mem[lane][k]      = 16'(t0[k]);
      tmpl_mem[lane][NF + k] = 16'(t1[k]);
    end
  endtask

  // Pulse start for one cycle; optionally register the expected result.
  task automatic kick(input int lane, input bit push, input int idx, input longint score);
    exp_t e;
    start_v[lane] = 1'b1;
    if (push) begin
      e.lane  = lane;
      e.cyc   = cyc + RUN_LEN;
      e.idx   = idx;
      e.score = score;
      sb.push_back(e);
    end
    @(negedge clk);
    start_v[lane] = 1'b0;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every done pulse must match a pending expectation for its lane.
  always @(negedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (done_v[l]) begin
        int k;
        k = -1;
        foreach (sb[j]) if (k < 0 && sb[j].lane == l) k = j;
        if (k < 0) begin
          check($sformatf("lane%0d_unexpected_done", l), done_v[l], 0);
        end else begin
          check($sformatf("lane%0d_done_cycle", l), cyc, sb[k].cyc);
          check($sformatf("lane%0d_best_idx", l), idx_v[l], sb[k].idx);
          check($sformatf("lane%0d_best_score", l), score_v[l], sb[k].score);
          sb.delete(k);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    rst     = 1'b1;
    start_v = '0;
    for (int l = 0; l < LANES; l++) set_lane(l, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0});
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_best_idx", idx_v[0], 0);
    check("rst_best_score", score_v[0], 32'hFFFF_FFFF);
    check("rst_best_score_17b", score_v[4], 17'h1_FFFF);
    check("rst_feat_addr", fa_v[0], 0);
    check("rst_tmpl_addr", ta_v[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: exact match on T0, timing and address sequencing.
    set_lane(0, '{1,2,3,4}, '{1,2,3,4}, '{0,0,0,0});
    c = cyc;
    check("t1_busy_c0", busy_v[0], 0);
    kick(0, 1'b1, 0, 0);
    check("t1_busy_c1", busy_v[0], 1);
    wait_to(c + 2);
    check("t1_feat_addr_c2", fa_v[0], 1);
    wait_to(c + 8);
    check("t1_tmpl_addr_c8", ta_v[0], 5);
    wait_to(c + 13);
    check("t1_busy_c13", busy_v[0], 1);
    check("t1_done_c13", done_v[0], 1);
    wait_to(c + 14);
    check("t1_busy_c14", busy_v[0], 0);
    check("t1_done_c14", done_v[0], 0);

    // 2: signed samples, T1 wins.
    set_lane(0, '{-3,0,0,0}, '{5,0,0,0}, '{-3,1,0,0});
    c = cyc;
    kick(0, 1'b1, 1, 1);
    wait_to(c + 15);

    // 3: tie keeps the lower index; result holds after done.
    set_lane(0, '{0,0,0,0}, '{2,2,2,2}, '{2,2,2,2});
    c = cyc;
    kick(0, 1'b1, 0, 8);
    wait_to(c + 16);
    check("t3_hold_score", score_v[0], 8);
    check("t3_hold_idx", idx_v[0], 0);

    // 4: 17-bit accumulator saturates instead of wrapping.
    set_lane(4, '{32767,32767,32767,32767}, '{-32768,-32768,-32768,-32768},
             '{32767,32767,32767,32767});
    c = cyc;
    kick(4, 1'b1, 1, 0);
    wait_to(c + 15);
    set_lane(4, '{32767,32767,32767,32767}, '{-32768,-32768,-32768,-32768},
             '{-32768,-32768,-32768,-32768});
    c = cyc;
    kick(4, 1'b1, 0, 131071);
    wait_to(c + 15);

    // 5a: start while busy and start during done are both ignored.
    set_lane(0, '{1,2,3,4}, '{1,2,3,4}, '{0,0,0,0});
    c = cyc;
    kick(0, 1'b1, 0, 0);
    wait_to(c + 5);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_to(c + 13);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("t5_start_at_done_ignored", busy_v[0], 0);
    wait_to(c + 16);
    check("t5_still_idle", busy_v[0], 0);

    // 5b: reset mid-run aborts with no done pulse.
    c = cyc;
    kick(0, 1'b0, 0, 0);
    wait_to(c + 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_busy", busy_v[0], 0);
    check("t5_rst_score", score_v[0], 32'hFFFF_FFFF);
    check("t5_rst_done", done_v[0], 0);
    wait_to(c + 22);

    // 5c: fresh start after reset completes normally.
    set_lane(0, '{-3,0,0,0}, '{5,0,0,0}, '{-3,1,0,0});
    c = cyc;
    kick(0, 1'b1, 1, 1);
    wait_to(c + 15);

    // 6: four staggered lanes into the aggregator model.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int l = 0; l < 4; l++) set_lane(l, '{l,l,0,0}, '{0,0,0,0}, '{l,l,1,0});
    c = cyc;
    kick(0, 1'b1, 0, 0);
    @(negedge clk);
    kick(1, 1'b1, 1, 1);
    @(negedge clk);
    kick(2, 1'b1, 1, 1);
    @(negedge clk);
    kick(3, 1'b1, 1, 1);
    wait_to(c + 17);
    check("t6_irq_before_last", irq, 0);
    wait_to(c + 19);
    check("t6_lane3_done", done_v[3], 1);
    check("t6_irq_at_last_done", irq, 0);
    wait_to(c + 20);
    check("t6_irq_after_last", irq, 1);
    wait_to(c + 24);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ai_template_comparer.md
Name: ai_template_comparer

Overview:
- One comparer lane of the speech classifier.
- Scores a stored feature vector against N_TEMPL stored templates using the sum of absolute differences (SAD).
- Keeps the index and score of the best (lowest-SAD) template.
- Emits a one-cycle `done` pulse that drives one `irq_in` input of the four-lane interrupt aggregator; four instances run in parallel, one per template bank.

Parameters:
- FEAT_W, 16, width of a signed feature/template sample.
- N_FEAT, 64, samples per vector; must be a power of two.
- N_TEMPL, 8, templates per bank; must be ≥ 1.
- ACC_W, 32, SAD accumulator and score width; must be ≥ FEAT_W+1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a comparison; honoured only in IDLE.
- feat_addr  out  log2(N_FEAT)  feature RAM read address.
- feat_data  in  FEAT_W  feature RAM read data, signed, valid 1 cycle after address.
- tmpl_addr  out  log2(N_TEMPL*N_FEAT)  template RAM address = {t, i}.
- tmpl_data  in  FEAT_W  template RAM read data, signed, 1-cycle latency.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion; goes to the aggregator's irq input.
- best_idx  out  max(1,log2(N_TEMPL))  index of the lowest-SAD template.
- best_score  out  ACC_W  SAD of best_idx.

Behaviour:
- Reset values: busy=0, done=0, best_idx=0, best_score=all-ones, feat_addr=0, tmpl_addr=0, state=IDLE.
- Internal state: accumulator, counters i and t.
- Reset mid-operation: immediate return to IDLE with the reset values above. No done pulse.

States: IDLE, RUN, DRAIN, CMP, DONE.
- IDLE: when start=1, clear i, t and the accumulator, then go to RUN. Outputs hold the last result.
- RUN: drive feat_addr=i and tmpl_addr={t,i}. Register a "data valid" flag one cycle behind the address.
  - When i==N_FEAT-1, go to DRAIN; otherwise i++.
- DRAIN: accumulate the final sample, then go to CMP.
- CMP: update the best result:
  - if t==0, or acc < best_score (strict), load best_score=acc and best_idx=t;
  - ties keep the lower index.
  - Then clear acc and i. If t==N_TEMPL-1, go to DONE; otherwise t++ and go to RUN.
- DONE: done=1 for exactly one cycle, then go to IDLE.

Accumulate rule:
- On every cycle where the data-valid flag is set, compute |feat_data − tmpl_data| on sign-extended (FEAT_W+1)-bit values. The result is unsigned and FEAT_W+1 bits wide.
- Zero-extend it to ACC_W and add it to acc.
- Saturating add: acc clamps at all-ones and never wraps.

Timing (start sampled at cycle 0):
- Template t occupies cycles t·(N_FEAT+2)+1 … (t+1)·(N_FEAT+2).
- done is high in cycle N_TEMPL·(N_FEAT+2)+1.

Output timing and restart:
- best_idx and best_score update only in CMP. They are stable and final while done=1, and hold until the next CMP of the next run.
- start while busy=1 is ignored. It is not queued.
- start in the same cycle as done: ignored. A new start is accepted from the following IDLE cycle.

Decomposition:
- Package ai_cmp_pkg holds:
  - state enum cmp_state_t {IDLE, RUN, DRAIN, CMP, DONE};
  - default width constants FEAT_W, ACC_W;
  - a function giving the address width from N_FEAT and N_TEMPL.
- One combinational sub-module, ai_abs_diff: signed a, b → unsigned |a−b| (FEAT_W+1 bits). It is shared with future distance lanes.
- The FSM, counters and saturating accumulator stay in the top module.

Test Plan (N_FEAT=4, N_TEMPL=2, RAM model with 1-cycle latency):
1. Features {1,2,3,4}; T0={1,2,3,4}; T1={0,0,0,0}; start at cycle 0 → done only at cycle 13; best_idx=0, best_score=0; busy high during cycles 1–13.
2. Features {-3,0,0,0}; T0={5,0,0,0}; T1={-3,1,0,0} → T0 SAD=8, T1 SAD=1; best_idx=1, best_score=1.
3. Tie: T0 and T1 both equal {2,2,2,2}, features {0,0,0,0} → both SAD=8; best_idx=0, best_score=8.
4. ACC_W=17: features all 32767, T0 all −32768, T1 all 32767 → T0 SAD saturates to 131071, no wrap; T1 SAD=0; best_idx=1, best_score=0.
5. Control edges:
   - start pulsed again at cycle 5 → ignored; done still only at cycle 13.
   - rst at cycle 7 → busy=0 and best_score=all-ones next cycle; no done pulse.
   - fresh start after reset → done at 13 cycles after that start.
6. Four instances feeding the aggregator:
   - lanes started on staggered cycles 0, 2, 4, 6 → each lane's done is a single-cycle pulse;
   - the aggregator irq rises only after the last lane's done.
